interrupt_arbiter: RTL and testbench
====================================

// Module: interrupt_arbiter
// PURPOSE
//  Collects the four interrupt sources of the accumulator CPU (overflow, bad opcode, bad
//  addressing mode, external "Daniel" line). Latches them as pending, masks them and arbitrates
//  by fixed or HVPI-selected priority. Raises a single request to the fetch-stage controller at
//  instruction boundaries and supplies the vector and the saved return PC. One interrupt is in
//  service at a time until iret.
// PARAMETERS
//  NSRC        4        number of interrupt sources (index 0 = overflow ... 3 = external)
//  AW          8        address width of PC / vector
//  VEC_BASE    8'd100   vector of source 0
//  VEC_STRIDE  8'd10    vector spacing: source i -> VEC_BASE + i*VEC_STRIDE (100,110,120,130)
// PORTS
//  clk             in   1     clock, all logic on rising edge
//  reset           in   1     synchronous, active-high
//  src_irq         in   NSRC  raw interrupt lines, rising-edge sensitive
//  irq_mask        in   NSRC  1 = source blocked from arbitration (still latched as pending)
//  hvpi            in   NSRC  one-hot high-priority select; 0 or non-one-hot = fixed priority
//  pc_in           in   AW    current fetch PC
//  fetch_boundary  in   1     1-cycle strobe: fetch controller is between instructions
//  irq_ack         in   1     fetch controller has loaded vector into PC
//  iret            in   1     1-cycle strobe: handler finished
//  irq_req         out  1     interrupt request to fetch controller
//  vector          out  AW    handler start address, valid while irq_req=1
//  ret_addr        out  AW    PC captured at the accepted boundary
//  active_id       out  2     index of the source being requested / serviced
//  in_service      out  1     handler running
//  pending         out  NSRC  latched pending sources
// BEHAVIOUR
//  Reset: state IDLE; irq_req=0, in_service=0, pending=0, vector=0, ret_addr=0, active_id=0,
//   edge-detect history=0. A reset in any state, including REQ or SERVICE, aborts to IDLE.
//  Pending: bit i set the cycle after a 0->1 edge on src_irq[i]. Cleared on irq_ack for
//   active_id. A new edge on the same bit in the ack cycle wins, so the bit stays set.
//  eligible = pending & ~irq_mask.
//  FSM:
//   IDLE: on fetch_boundary && |eligible: ret_addr<=pc_in, go ARB.
//   ARB: recompute eligible.
//    - If none are eligible (masked meanwhile), go IDLE.
//    - Otherwise the winner is the hvpi bit if hvpi is one-hot and that bit is eligible.
//    - Otherwise the winner is the lowest eligible index.
//    - Load active_id and vector=VEC_BASE+id*VEC_STRIDE (mod 2^AW), go REQ.
//   REQ: irq_req=1, held with vector/active_id stable until irq_ack.
//    - On irq_ack: clear pending[active_id], irq_req<=0, in_service<=1, go SERVICE.
//    - Mask changes during REQ do not withdraw the request.
//   SERVICE: no nesting; new edges are still latched as pending.
//    - On iret: in_service<=0, go IDLE.
//    - fetch_boundary is ignored.
//  irq_ack outside REQ and iret outside SERVICE are ignored.
//  Latency: boundary in cycle n (IDLE) -> ARB n+1 -> irq_req=1 from n+2.
//   irq_ack in cycle m -> irq_req=0 and in_service=1 from m+1.
//  A boundary in the same cycle as a src edge does not see that edge; the next boundary does.
//  All outputs are registered.
// TESTING
//  1 Edge on src_irq[0], boundary with pc_in=8'h2A -> irq_req, vector=100, ret_addr=8'h2A, id=0.
//    Then ack -> pending[0]=0, in_service=1.
//  2 Sources 1 and 3 pending, hvpi=4'b1000 -> vector=130.
//    Same with hvpi=4'b0011 (non-one-hot) -> vector=110.
//  3 src 2 pending with irq_mask[2]=1, boundaries -> no irq_req.
//    Clear mask, boundary -> vector=120.
//  4 In SERVICE, edge on src 0 -> pending[0]=1, no irq_req.
//    iret, boundary -> new request id=0.
//  5 Hold irq_ack low 5 cycles in REQ -> irq_req and vector stable.
//    Assert reset -> all outputs 0, state IDLE next cycle.
//  6 Edge on src 1 in the same cycle as irq_ack for id 1 -> pending[1] remains 1.

Source files
------------

// File: rtl/interrupt_arbiter.sv
// interrupt_arbiter: latches, masks and prioritises CPU interrupt sources and hands one to the fetch controller
module interrupt_arbiter #(
  parameter int NSRC = 4,
  parameter int AW = 8,
  parameter logic [AW-1:0] VEC_BASE = 8'd100,
  parameter logic [AW-1:0] VEC_STRIDE = 8'd10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src_irq,
  input  logic [NSRC-1:0] irq_mask,
  input  logic [NSRC-1:0] hvpi,
  input  logic [AW-1:0]   pc_in,
  input  logic            fetch_boundary,
  input  logic            irq_ack,
  input  logic            iret,
  output logic            irq_req,
  output logic [AW-1:0]   vector,
  output logic [AW-1:0]   ret_addr,
  output logic [1:0]      active_id,
  output logic            in_service,
  output logic [NSRC-1:0] pending
);
  typedef enum logic [1:0] {IDLE, ARB, REQ, SERVICE} state_t;
  state_t state, stateNext;
  logic [NSRC-1:0] srcPrev, eligible, clearMask, pendingNext;
  logic [1:0] lowId, hvpiId, winId, idNext;
  logic [AW-1:0] vecNext, retNext;
  logic reqNext, svcNext, hvpiWin;
  assign eligible = pending & ~irq_mask;
  assign clearMask = (state == REQ && irq_ack) ? NSRC'(1) << active_id : '0;
  assign pendingNext = (pending & ~clearMask) | (src_irq & ~srcPrev);
  assign hvpiWin = $onehot(hvpi) && |(hvpi & eligible);
  assign winId = hvpiWin ? hvpiId : lowId;
  // lowest eligible index and the index selected by the hvpi bit
  always_comb begin
    lowId = '0;
    hvpiId = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (eligible[i]) lowId = 2'(i);
      if (hvpi[i]) hvpiId = 2'(i);
    end
  end
  // next state and next values of the registered outputs
  always_comb begin
    stateNext = state;
    reqNext = irq_req;
    vecNext = vector;
    retNext = ret_addr;
    idNext = active_id;
    svcNext = in_service;
    case (state)
      IDLE: if (fetch_boundary && |eligible) begin
        retNext = pc_in;
        stateNext = ARB;
      end
      ARB: if (|eligible) begin
        idNext = winId;
        vecNext = VEC_BASE + AW'(winId) * VEC_STRIDE;
        reqNext = 1'b1;
        stateNext = REQ;
      end else stateNext = IDLE;
      REQ: if (irq_ack) begin
        reqNext = 1'b0;
        svcNext = 1'b1;
        stateNext = SERVICE;
      end
      SERVICE: if (iret) begin
        svcNext = 1'b0;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end
  // state, edge history and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      srcPrev <= '0;
      pending <= '0;
      irq_req <= 1'b0;
      vector <= '0;
      ret_addr <= '0;
      active_id <= '0;
      in_service <= 1'b0;
    end else begin
      state <= stateNext;
      srcPrev <= src_irq;
      pending <= pendingNext;
      irq_req <= reqNext;
      vector <= vecNext;
      ret_addr <= retNext;
      active_id <= idNext;
      in_service <= svcNext;
    end
  end
endmodule

// File: tb/tb_interrupt_arbiter.sv
// tb_interrupt_arbiter: directed self-checking bench for interrupt_arbiter
module tb_interrupt_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] src_irq = '0, irq_mask = '0, hvpi = '0;
  logic [7:0] pc_in = '0;
  logic fetch_boundary = 1'b0, irq_ack = 1'b0, iret = 1'b0;
  logic irq_req, in_service;
  logic [7:0] vector, ret_addr;
  logic [1:0] active_id;
  logic [3:0] pending;
  int passCnt = 0, failCnt = 0, total = 0;

  interrupt_arbiter dut (
    .clk(clk), .reset(reset), .src_irq(src_irq), .irq_mask(irq_mask), .hvpi(hvpi),
    .pc_in(pc_in), .fetch_boundary(fetch_boundary), .irq_ack(irq_ack), .iret(iret),
    .irq_req(irq_req), .vector(vector), .ret_addr(ret_addr), .active_id(active_id),
    .in_service(in_service), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passCnt++;
    else begin
      failCnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic [3:0] bits);
    src_irq = bits;
    tick();
    src_irq = '0;
    tick();
  endtask

  task automatic boundary(input logic [7:0] pc);
    fetch_boundary = 1'b1;
    pc_in = pc;
    tick();
    fetch_boundary = 1'b0;
    tick();
  endtask

  task automatic ack();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  task automatic doIret();
    iret = 1'b1;
    tick();
    iret = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    chk("rst_req", irq_req, 0);
    chk("rst_vec", vector, 0);
    chk("rst_ret", ret_addr, 0);
    chk("rst_id", active_id, 0);
    chk("rst_svc", in_service, 0);
    chk("rst_pend", pending, 0);
    reset = 1'b0;
    tick();
    // basic request on source 0
    pulse(4'b0001);
    chk("t1_pend", pending, 4'b0001);
    boundary(8'h2A);
    chk("t1_req", irq_req, 1);
    chk("t1_vec", vector, 100);
    chk("t1_ret", ret_addr, 8'h2A);
    chk("t1_id", active_id, 0);
    ack();
    chk("t1_ack_req", irq_req, 0);
    chk("t1_ack_svc", in_service, 1);
    chk("t1_ack_pend", pending, 0);
    doIret();
    chk("t1_iret_svc", in_service, 0);
    // hvpi one-hot vs non-one-hot
    pulse(4'b1010);
    hvpi = 4'b1000;
    boundary(8'h10);
    chk("t2_hvpi_vec", vector, 130);
    chk("t2_hvpi_id", active_id, 3);
    ack();
    chk("t2_pend", pending, 4'b0010);
    doIret();
    hvpi = 4'b0011;
    boundary(8'h11);
    chk("t2_fixed_vec", vector, 110);
    chk("t2_fixed_id", active_id, 1);
    ack();
    doIret();
    hvpi = '0;
    // masking
    irq_mask = 4'b0100;
    pulse(4'b0100);
    chk("t3_pend", pending, 4'b0100);
    boundary(8'h20);
    chk("t3_masked1", irq_req, 0);
    boundary(8'h21);
    chk("t3_masked2", irq_req, 0);
    irq_mask = '0;
    boundary(8'h33);
    chk("t3_vec", vector, 120);
    chk("t3_ret", ret_addr, 8'h33);
    ack();
    chk("t3_pend_clr", pending, 0);
    chk("t3_svc", in_service, 1);
    // no nesting while in service
    pulse(4'b0001);
    chk("t4_pend", pending, 4'b0001);
    chk("t4_noreq", irq_req, 0);
    boundary(8'h40);
    chk("t4_bnd_ignored", irq_req, 0);
    doIret();
    chk("t4_iret", in_service, 0);
    boundary(8'h44);
    chk("t4_req", irq_req, 1);
    chk("t4_id", active_id, 0);
    chk("t4_vec", vector, 100);
    // request held without ack, and mask changes do not withdraw it
    irq_mask = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_hold_req", irq_req, 1);
      chk("t5_hold_vec", vector, 100);
    end
    irq_mask = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_rst_req", irq_req, 0);
    chk("t5_rst_vec", vector, 0);
    chk("t5_rst_ret", ret_addr, 0);
    chk("t5_rst_svc", in_service, 0);
    chk("t5_rst_pend", pending, 0);
    doIret();
    chk("t5_iret_ignored", in_service, 0);
    // edge in the ack cycle keeps the bit pending
    pulse(4'b0010);
    boundary(8'h55);
    chk("t6_id", active_id, 1);
    src_irq = 4'b0010;
    irq_ack = 1'b1;
    tick();
    src_irq = '0;
    irq_ack = 1'b0;
    chk("t6_pend_kept", pending, 4'b0010);
    chk("t6_svc", in_service, 1);
    doIret();
    boundary(8'h56);
    chk("t6_rereq_vec", vector, 110);
    ack();
    doIret();
    // boundary coincident with the edge misses it
    src_irq = 4'b0001;
    fetch_boundary = 1'b1;
    tick();
    src_irq = '0;
    fetch_boundary = 1'b0;
    tick();
    tick();
    chk("t7_same_cycle", irq_req, 0);
    boundary(8'h60);
    chk("t7_next_bnd", irq_req, 1);
    ack();
    doIret();
    // mask raised during arbitration drops back to idle
    pulse(4'b0001);
    fetch_boundary = 1'b1;
    tick();
    fetch_boundary = 1'b0;
    irq_mask = 4'b1111;
    tick();
    tick();
    chk("t8_arb_masked", irq_req, 0);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    chk("t8_ack_ignored", in_service, 0);
    chk("t8_pend", pending, 4'b0001);
    $display("%0d/%0d checks passed", passCnt, total);
    $finish;
  end
endmodule
